// File: rtl/icache_dm_pkg.sv
// Purpose: shared constants for the direct-mapped instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_dm_pkg;

    localparam int TAG_WD    = 20;
    localparam int INDEX_WD  = 8;
    localparam int OFFSET_WD = 4;

    // Bridge read-request types.
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    // Controller states.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

endpackage

// File: rtl/icache_line_ram.sv
// Purpose: valid/tag/data storage for the cache; valid bits clear on reset, tag/data do not.
// Latency: combinational read, write lands on the clock edge.
// Backpressure: none; a write is always accepted.
module icache_line_ram
    import icache_dm_pkg::*;
#(
    parameter int SETS   = 256,
    parameter int LINE_W = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_WD-1:0] rd_index,
    output logic                rd_valid,
    output logic [TAG_WD-1:0]   rd_tag,
    output logic [LINE_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_WD-1:0] wr_index,
    input  logic [TAG_WD-1:0]   wr_tag,
    input  logic [LINE_W-1:0]   wr_data
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_WD-1:0] tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    logic [SETS-1:0]   valid_d;

    // Next valid vector: set the written line's bit.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Valid bits are the only storage that needs a known state after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays: plain write port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Purpose: blocking direct-mapped icache; misses/uncached fetches go out as a burst/single read.
// Latency: hit data one cycle after handshake; miss = lookup + request + beats + response cycle.
// Backpressure: addr_ok drops while a miss is in flight; rd_req holds until rd_rdy.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [TAG_WD-1:0]    tag,
    input  logic [INDEX_WD-1:0]  index,
    input  logic [OFFSET_WD-1:0] offset,
    input  logic                 uncached,
    output logic                 addr_ok,
    output logic                 data_ok,
    output logic [31:0]          rdata,
    output logic                 rd_req,
    output logic [2:0]           rd_type,
    output logic [31:0]          rd_addr,
    input  logic                 rd_rdy,
    input  logic                 ret_valid,
    input  logic                 ret_last,
    input  logic [31:0]          ret_data
);

    localparam int LINE_W = LINE_WORDS * 32;

    logic [2:0]           state_q,    state_d;
    logic [TAG_WD-1:0]    tag_q,      tag_d;
    logic [INDEX_WD-1:0]  index_q,    index_d;
    logic [OFFSET_WD-1:0] offset_q,   offset_d;
    logic                 uncached_q, uncached_d;
    logic [1:0]           beat_q,     beat_d;
    logic [LINE_W-1:0]    line_q,     line_d;

    logic                 ram_valid;
    logic [TAG_WD-1:0]    ram_tag;
    logic [LINE_W-1:0]    ram_data;
    logic                 ram_we;
    logic                 hit;

    icache_line_ram #(
        .SETS   (SETS),
        .LINE_W (LINE_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .rd_index (index_q),
        .rd_valid (ram_valid),
        .rd_tag   (ram_tag),
        .rd_data  (ram_data),
        .wr_en    (ram_we),
        .wr_index (index_q),
        .wr_tag   (tag_q),
        .wr_data  (line_d)
    );

    assign hit = !uncached_q && ram_valid && (ram_tag == tag_q);

    // Controller: request buffering, hit/miss decision, refill collection and response.
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        index_d    = index_q;
        offset_d   = offset_q;
        uncached_d = uncached_q;
        beat_d     = beat_q;
        line_d     = line_q;
        addr_ok    = 1'b0;
        data_ok    = 1'b0;
        rdata      = 32'd0;
        rd_req     = 1'b0;
        rd_type    = 3'd0;
        rd_addr    = 32'd0;
        ram_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                addr_ok = 1'b1;
                if (valid) begin
                    tag_d      = tag;
                    index_d    = index;
                    offset_d   = offset;
                    uncached_d = uncached;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = ram_data[{offset_q[3:2], 5'b0} +: 32];
                    // A hit frees the buffer at once so fetches can stream one per cycle.
                    addr_ok = 1'b1;
                    if (valid) begin
                        tag_d      = tag;
                        index_d    = index;
                        offset_d   = offset;
                        uncached_d = uncached;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_type = uncached_q ? RD_WORD : RD_LINE;
                rd_addr = uncached_q ? {tag_q, index_q, offset_q}
                                     : {tag_q, index_q, 4'b0};
                if (rd_rdy) begin
                    beat_d  = 2'd0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (ret_valid) begin
                    line_d[{beat_q, 5'b0} +: 32] = ret_data;
                    beat_d = beat_q + 2'd1;
                    if (ret_last) begin
                        // line_d already holds the final beat, so the array gets the full line.
                        ram_we  = !uncached_q;
                        beat_d  = 2'd0;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                data_ok = 1'b1;
                rdata   = uncached_q ? line_q[31:0] : line_q[{offset_q[3:2], 5'b0} +: 32];
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and request buffer; reset abandons any refill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            offset_q   <= '0;
            uncached_q <= 1'b0;
            beat_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            offset_q   <= offset_d;
            uncached_q <= uncached_d;
            beat_q     <= beat_d;
        end
    end

    // Line buffer contents are only meaningful after a completed refill.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [19:0] tag;
    logic [7:0]  index;
    logic [3:0]  offset;
    logic        uncached;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    int total = 0;
    int bad   = 0;

    // Reference model: which memory line each set currently holds.
    bit         m_valid [256];
    logic [19:0] m_tag  [256];

    always #5 clk = ~clk;

    icache_dm dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .tag       (tag),
        .index     (index),
        .offset    (offset),
        .uncached  (uncached),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
    );

    // Backing memory contents: fixed words for the directed tests, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h1fc00000: w = 32'hA0;
            32'h1fc00004: w = 32'hA1;
            32'h1fc00008: w = 32'hA2;
            32'h1fc0000c: w = 32'hA3;
            32'h1faf0008: w = 32'hDEAD;
            default:      w = {a[15:0] ^ 16'hc3a5, a[31:16] + 16'h1357};
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete fetch, starting and ending at a falling edge with the cache idle.
    task automatic fetch(input logic [19:0] t, input logic [7:0] idx, input logic [3:0] off,
                         input logic unc, output logic hit_seen);
        logic [31:0] a;
        logic [31:0] base;
        logic        exp_hit;
        logic        took;
        int          nbeats;
        a       = {t, idx, off};
        base    = unc ? a : {t, idx, 4'b0};
        exp_hit = !unc && m_valid[idx] && (m_tag[idx] == t);
        valid    = 1'b1;
        tag      = t;
        index    = idx;
        offset   = off;
        uncached = unc;
        chk("accept", {31'd0, addr_ok}, 32'd1);
        cyc();
        valid    = 1'b0;
        hit_seen = data_ok;
        chk("lookup_data_ok", {31'd0, data_ok}, {31'd0, exp_hit});
        if (exp_hit) begin
            chk("hit_rdata", rdata, mem_word(a));
            chk("hit_no_rd_req", {31'd0, rd_req}, 32'd0);
            cyc();
            return;
        end
        chk("miss_addr_ok", {31'd0, addr_ok}, 32'd0);
        cyc();
        took = 1'b0;
        for (int n = 0; n < 20 && !took; n++) begin
            chk("rd_req", {31'd0, rd_req}, 32'd1);
            chk("rd_type", {29'd0, rd_type}, unc ? 32'd2 : 32'd4);
            chk("rd_addr", rd_addr, base);
            rd_rdy = (n >= 3) || ($urandom_range(0, 2) == 0);
            took   = rd_rdy;
            cyc();
            rd_rdy = 1'b0;
        end
        if (!took) begin
            chk("rd_rdy_timeout", 32'd0, 32'd1);
            return;
        end
        nbeats = unc ? 1 : 4;
        for (int k = 0; k < nbeats; k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                chk("refill_gap_data_ok", {31'd0, data_ok}, 32'd0);
                cyc();
            end
            ret_valid = 1'b1;
            ret_data  = mem_word(base + 32'(4 * k));
            ret_last  = (k == nbeats - 1);
            cyc();
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            ret_data  = 32'hx;
        end
        chk("resp_data_ok", {31'd0, data_ok}, 32'd1);
        chk("resp_rdata", rdata, mem_word(a));
        chk("resp_addr_ok", {31'd0, addr_ok}, 32'd0);
        if (!unc) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
        end
        cyc();
    endtask

    initial begin
        logic h;
        logic [19:0] tags [4];
        tags[0] = 20'h1fc00;
        tags[1] = 20'h00001;
        tags[2] = 20'h00002;
        tags[3] = 20'h0abcd;
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        reset     = 1'b1;
        valid     = 1'b0;
        tag       = '0;
        index     = '0;
        offset    = '0;
        uncached  = 1'b0;
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        cyc();
        cyc();

        // Reset state.
        chk("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
        chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
        chk("rst_rd_type", {29'd0, rd_type}, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        reset = 1'b0;
        cyc();

        // Cold miss, then warm hit on the same line.
        fetch(20'h1fc00, 8'd0, 4'd4, 1'b0, h);
        chk("cold_is_miss", {31'd0, h}, 32'd0);
        fetch(20'h1fc00, 8'd0, 4'd12, 1'b0, h);
        chk("warm_is_hit", {31'd0, h}, 32'd1);

        // Back-to-back hits at one fetch per cycle.
        for (int i = 0; i < 4; i++) begin
            valid    = 1'b1;
            tag      = 20'h1fc00;
            index    = 8'd0;
            offset   = 4'(i * 4);
            uncached = 1'b0;
            chk("b2b_addr_ok", {31'd0, addr_ok}, 32'd1);
            if (i > 0) begin
                chk("b2b_data_ok", {31'd0, data_ok}, 32'd1);
                chk("b2b_rdata", rdata, 32'hA0 + 32'(i - 1));
            end
            cyc();
        end
        valid = 1'b0;
        chk("b2b_last_data_ok", {31'd0, data_ok}, 32'd1);
        chk("b2b_last_rdata", rdata, 32'hA3);
        cyc();

        // Uncached fetch, then a cached fetch to the same set still misses.
        fetch(20'h1faf0, 8'd0, 4'd8, 1'b1, h);
        chk("uncached_no_hit", {31'd0, h}, 32'd0);
        fetch(20'h1faf0, 8'd0, 4'd8, 1'b0, h);
        chk("after_uncached_miss", {31'd0, h}, 32'd0);

        // Conflict: two tags sharing set 0 evict each other.
        fetch(20'h00001, 8'd0, 4'd0, 1'b0, h);
        chk("conflict_first_miss", {31'd0, h}, 32'd0);
        fetch(20'h1fc00, 8'd0, 4'd8, 1'b0, h);
        chk("conflict_second_miss", {31'd0, h}, 32'd0);
        fetch(20'h1fc00, 8'd0, 4'd0, 1'b0, h);
        chk("conflict_refetched_hit", {31'd0, h}, 32'd1);

        // Reset after two beats of a line refill.
        valid  = 1'b1;
        tag    = 20'h00002;
        index  = 8'd0;
        offset = 4'd0;
        cyc();
        valid = 1'b0;
        cyc();
        chk("mid_rd_req", {31'd0, rd_req}, 32'd1);
        rd_rdy = 1'b1;
        cyc();
        rd_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ret_valid = 1'b1;
            ret_data  = mem_word({20'h00002, 8'd0, 4'd0} + 32'(4 * k));
            cyc();
        end
        ret_valid = 1'b0;
        reset     = 1'b1;
        cyc();
        chk("mid_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
        chk("mid_rst_data_ok", {31'd0, data_ok}, 32'd0);
        chk("mid_rst_rd_req", {31'd0, rd_req}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        cyc();
        fetch(20'h00002, 8'd0, 4'd0, 1'b0, h);
        chk("mid_rst_remiss", {31'd0, h}, 32'd0);
        fetch(20'h1fc00, 8'd0, 4'd4, 1'b0, h);
        chk("mid_rst_old_line_gone", {31'd0, h}, 32'd0);

        // Random fetches over a few conflicting tags and sets.
        for (int r = 0; r < 80; r++) begin
            fetch(tags[$urandom_range(0, 3)], 8'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3) * 4), ($urandom_range(0, 5) == 0), h);
            for (int g = $urandom_range(0, 1); g > 0; g--) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, blocking instruction cache that answers the fetch stage's icache request port: valid/tag/index/offset/uncached in, addr_ok/data_ok/rdata out. Capacity is 4 KiB: 256 sets × 16-byte lines, physical tag 20 bits. Misses and uncached fetches go through a read-only burst port to the AXI bridge. The block sits between the pre-fetch stage (initiator) and the memory bridge.

## Interface
Parameters
- `SETS`, default 256: number of lines; index width is log2(SETS) = 8.
- `LINE_WORDS`, default 4: 32-bit words per line; offset width is 4.

Ports
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `valid`  in  1: fetch request.
- `tag`  in  20: physical address [31:12].
- `index`  in  8: address [11:4].
- `offset`  in  4: address [3:0]; bits [1:0] are always 0.
- `uncached`  in  1: bypass the cache arrays.
- `addr_ok`  out  1: request accepted this cycle.
- `data_ok`  out  1: instruction returned this cycle.
- `rdata`  out  32: instruction word.
- `rd_req`  out  1: memory read request.
- `rd_type`  out  3: 3'b010 = single word, 3'b100 = line burst.
- `rd_addr`  out  32: memory read address.
- `rd_rdy`  in  1: bridge accepts `rd_req`.
- `ret_valid`  in  1: return beat valid.
- `ret_last`  in  1: final beat.
- `ret_data`  in  32: return beat data.

## Operation
- Storage:
  - valid bit array: 256 bits, cleared by reset.
  - tag array: 256 × 20 bits, not reset.
  - data array: 256 × 128 bits, not reset.
- Request buffer: on `valid && addr_ok` latch {tag, index, offset, uncached}.
- FSM states: IDLE, LOOKUP, MISS, REFILL, RESP.
- IDLE:
  - `addr_ok = 1`.
  - On handshake go to LOOKUP.
- LOOKUP:
  - hit = !uncached_r && valid_arr[index_r] && tag_arr[index_r] == tag_r.
  - On hit: `data_ok = 1`, `rdata` = data_arr[index_r] word offset_r[3:2].
  - On hit, `addr_ok = 1`. A new request accepted in the same cycle stays in LOOKUP; otherwise go to IDLE.
  - On miss or uncached: `addr_ok = 0`, go to MISS.
- MISS:
  - Hold `rd_req = 1` until `rd_rdy`, then go to REFILL.
  - Cached miss: `rd_type = 3'b100`, `rd_addr = {tag_r, index_r, 4'b0}`.
  - Uncached: `rd_type = 3'b010`, `rd_addr = {tag_r, index_r, offset_r}`.
- REFILL:
  - Collect beats into a 128-bit line buffer using a 2-bit beat counter, word 0 first.
  - On `ret_valid && ret_last` go to RESP.
  - For a cached miss, write line buffer, tag, and valid = 1 into set index_r in that same cycle.
- RESP:
  - `data_ok = 1`; `rdata` = line buffer word offset_r[3:2] (cached) or word 0 (uncached).
  - `addr_ok = 0`; go to IDLE.
- Uncached fetches never modify any array.
- A cached miss replaces the line unconditionally; there is no dirty state.
- No more than one request is outstanding, and `data_ok` order equals request order.

## Timing
- Reset values: state IDLE, all valid bits 0, `addr_ok = 1`, `data_ok = 0`, `rdata = 0`, `rd_req = 0`, `rd_type = 0`, `rd_addr = 0`, beat counter 0.
- Hit latency: `data_ok` one cycle after the `addr_ok` handshake. Back-to-back hits sustain 1 fetch per cycle.
- Miss latency: handshake → LOOKUP (1 cycle) → MISS (≥1 cycle, ends on `rd_rdy`) → REFILL (4 beats cached, 1 uncached) → RESP (1 cycle).
- The array write in the `ret_last` cycle is visible to a LOOKUP two cycles later, i.e. the next request after RESP/IDLE.
- `rd_req`, `rd_type` and `rd_addr` stay stable from assertion until `rd_rdy`.
- Beats arriving with `ret_valid = 0` are ignored. Gaps between beats are legal.
- Reset mid-miss: the FSM returns to IDLE immediately and the bridge is reset by the same `reset`.
- Reset mid-miss: the partially filled line buffer is discarded and no array write occurs.
- `valid` while `addr_ok = 0` is not accepted. The initiator holds or re-presents the request.

## Structure
- Shared package holds:
  - the `rd_type` encodings, `RD_WORD = 3'b010` and `RD_LINE = 3'b100`;
  - the FSM state encodings;
  - the `TAG_WD = 20`, `INDEX_WD = 8` and `OFFSET_WD = 4` constants.
- One sub-module, `icache_line_ram`: the tag/valid/data storage with a combinational read port and a synchronous write port. The valid array is reset inside it.

## Test plan
- Cold miss:
  - Stimulus: request tag 20'h1fc00, index 0, offset 4; bridge returns 32'hA0, 32'hA1, 32'hA2, 32'hA3.
  - Response: `rd_req` with `rd_addr = 32'h1fc00000`, `rd_type = 3'b100`; then `data_ok` with `rdata = 32'hA1`.
- Warm hit:
  - Stimulus: same line, offset 12.
  - Response: `data_ok` the next cycle with `rdata = 32'hA3`, and no `rd_req`.
- Back-to-back hits:
  - Stimulus: requests to offsets 0, 4, 8, 12 on consecutive cycles.
  - Response: `addr_ok` held high, `data_ok` on 4 consecutive cycles returning `32'hA0`..`32'hA3` in order.
- Uncached:
  - Stimulus: `uncached = 1` at address 32'h1faf0008; bridge returns 32'hDEAD.
  - Response: `rd_type = 3'b010`, `rd_addr = 32'h1faf0008`, `rdata = 32'hDEAD`.
  - Follow-up: a cached request to the same set still misses.
- Conflict:
  - Stimulus: cached miss to tag 20'h00001, index 0, then a request to tag 20'h1fc00, index 0.
  - Response: the second request misses and refetches its line.
- Reset mid-refill:
  - Stimulus: assert `reset` after beat 2 of a line refill.
  - Response: next cycle `addr_ok = 1`, `data_ok = 0`, `rd_req = 0`; a re-request to that line misses.
